// File: rtl/cpu_bus_regbank_ctrl.sv
// CPU-to-fabric bus decoder for the function generator.
// Synchronises the asynchronous CPU strobes, commits writes on the NWE rising
// edge into a per-channel control bank, command pulses or waveform-RAM ports,
// serves register/status readback and counts writes to unmapped addresses.
module cpu_bus_regbank_ctrl #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 16,
    parameter int NUM_CH      = 2,
    parameter int REGS_PER_CH = 8,
    parameter int RAM_AW      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int REG_PAGE    = 0,
    parameter int RAM_PAGE    = 1
) (
    input  logic                                 Clock,
    input  logic                                 Reset,
    input  logic                                 CPU_NCS,
    input  logic                                 CPU_NWE,
    input  logic                                 CPU_NRD,
    input  logic [ADDR_W-1:0]                    CPU_Addr,
    input  logic [DATA_W-1:0]                    CPU_Data_In,
    output logic [DATA_W-1:0]                    CPU_Data_Out,
    output logic                                 Bus_Oe,
    input  logic [NUM_CH*DATA_W-1:0]             Status_In,
    output logic [NUM_CH*REGS_PER_CH*DATA_W-1:0] Ctrl_Reg,
    output logic [NUM_CH*DATA_W-1:0]             Cmd_Pulse,
    output logic [NUM_CH-1:0]                    Ram_We,
    output logic [RAM_AW-1:0]                    Ram_Addr,
    output logic [DATA_W-1:0]                    Ram_Data,
    output logic [7:0]                           Err_Cnt
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RI_W    = $clog2(REGS_PER_CH);
    localparam int RPG_LSB = RI_W + CH_W + 1;
    localparam int MPG_LSB = RAM_AW + CH_W + 1;
    localparam int RPG_W   = ADDR_W - RPG_LSB;
    localparam int MPG_W   = ADDR_W - MPG_LSB;

    localparam logic [RI_W-1:0]  IDX_CMD  = '0;
    localparam logic [RI_W-1:0]  IDX_STAT = RI_W'(REGS_PER_CH - 1);
    localparam logic [RPG_W-1:0] REG_PG   = RPG_W'(REG_PAGE);
    localparam logic [MPG_W-1:0] RAM_PG   = MPG_W'(RAM_PAGE);

    // True when a decoded channel number refers to an existing channel.
    function automatic logic ch_ok(input logic [CH_W-1:0] ch);
        ch_ok = ({1'b0, ch} < (CH_W + 1)'(NUM_CH));
    endfunction

    // ------------------------------------------------------------------
    // Strobe synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ncs_sync_r;
    logic [SYNC_STAGES-1:0] nwe_sync_r;
    logic [SYNC_STAGES-1:0] nrd_sync_r;
    logic [SYNC_STAGES-1:0] sync_vld_r;
    logic                   sncs_s;
    logic                   snwe_s;
    logic                   snrd_s;
    logic                   sync_ok_s;

    // Strobe synchroniser chains; preset idle-high, validity tracks real samples.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ncs_sync_r <= '1;
            nwe_sync_r <= '1;
            nrd_sync_r <= '1;
            sync_vld_r <= '0;
        end else begin
            ncs_sync_r <= {ncs_sync_r[SYNC_STAGES-2:0], CPU_NCS};
            nwe_sync_r <= {nwe_sync_r[SYNC_STAGES-2:0], CPU_NWE};
            nrd_sync_r <= {nrd_sync_r[SYNC_STAGES-2:0], CPU_NRD};
            sync_vld_r <= {sync_vld_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sncs_s    = ncs_sync_r[SYNC_STAGES-1];
    assign snwe_s    = nwe_sync_r[SYNC_STAGES-1];
    assign snrd_s    = nrd_sync_r[SYNC_STAGES-1];
    assign sync_ok_s = sync_vld_r[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Edge detection. A strobe is armed only after it has been seen idle
    // (high) through a fully refilled synchroniser, so an access that was
    // in flight across reset can never produce a write or read event.
    // ------------------------------------------------------------------
    logic nwe_prev_r;
    logic nrd_prev_r;
    logic wr_arm_r;
    logic rd_arm_r;
    logic wr_evt_s;
    logic rd_evt_s;

    // Previous strobe levels and post-reset arming flags.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            nwe_prev_r <= 1'b1;
            nrd_prev_r <= 1'b1;
            wr_arm_r   <= 1'b0;
            rd_arm_r   <= 1'b0;
        end else begin
            nwe_prev_r <= snwe_s;
            nrd_prev_r <= snrd_s;
            wr_arm_r   <= wr_arm_r | (sync_ok_s & snwe_s);
            rd_arm_r   <= rd_arm_r | (sync_ok_s & snrd_s);
        end
    end

    assign wr_evt_s = wr_arm_r & ~nwe_prev_r & snwe_s & ~sncs_s;
    // Writes win: a read falling edge seen while NWE is low is discarded.
    assign rd_evt_s = rd_arm_r & nrd_prev_r & ~snrd_s & ~sncs_s & snwe_s;

    // ------------------------------------------------------------------
    // Write holding register (address bit 0 is a byte lane, ignored)
    // ------------------------------------------------------------------
    logic [ADDR_W-1:1] hold_addr_r;
    logic [DATA_W-1:0] hold_data_r;
    logic              addr_lsb_unused_s;

    assign addr_lsb_unused_s = CPU_Addr[0];

    // Capture pad address/data while the synchronised write strobe is active.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold_addr_r <= '0;
            hold_data_r <= '0;
        end else if (!sncs_s && !snwe_s) begin
            hold_addr_r <= CPU_Addr[ADDR_W-1:1];
            hold_data_r <= CPU_Data_In;
        end else begin
            hold_addr_r <= hold_addr_r;
            hold_data_r <= hold_data_r;
        end
    end

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic [RPG_W-1:0]  w_rpage_s;
    logic [CH_W-1:0]   w_rch_s;
    logic [RI_W-1:0]   w_idx_s;
    logic [MPG_W-1:0]  w_mpage_s;
    logic [CH_W-1:0]   w_mch_s;
    logic [RAM_AW-1:0] w_word_s;
    logic              wr_cmd_s;
    logic              wr_reg_s;
    logic              wr_ram_s;
    logic              wr_err_s;

    assign w_rpage_s = hold_addr_r[ADDR_W-1:RPG_LSB];
    assign w_rch_s   = hold_addr_r[RI_W+CH_W:RI_W+1];
    assign w_idx_s   = hold_addr_r[RI_W:1];
    assign w_mpage_s = hold_addr_r[ADDR_W-1:MPG_LSB];
    assign w_mch_s   = hold_addr_r[RAM_AW+CH_W:RAM_AW+1];
    assign w_word_s  = hold_addr_r[RAM_AW:1];

    // Classify a committed write as command, register, RAM or unmapped.
    always_comb begin
        wr_cmd_s = 1'b0;
        wr_reg_s = 1'b0;
        wr_ram_s = 1'b0;
        wr_err_s = 1'b0;
        if (wr_evt_s) begin
            if (w_rpage_s == REG_PG) begin
                if (ch_ok(w_rch_s)) begin
                    if (w_idx_s == IDX_CMD) begin
                        wr_cmd_s = 1'b1;
                    end else if (w_idx_s == IDX_STAT) begin
                        wr_reg_s = 1'b0;   // status slot is read-only, silently ignored
                    end else begin
                        wr_reg_s = 1'b1;
                    end
                end else begin
                    wr_err_s = 1'b1;
                end
            end else if (w_mpage_s == RAM_PG) begin
                if (ch_ok(w_mch_s)) begin
                    wr_ram_s = 1'b1;
                end else begin
                    wr_err_s = 1'b1;
                end
            end else begin
                wr_err_s = 1'b1;
            end
        end else begin
            wr_err_s = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control-register bank and command pulses
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ctrl_r [NUM_CH][REGS_PER_CH];
    logic [DATA_W-1:0] cmd_r  [NUM_CH];

    // Store register writes; command and status slots stay at zero.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < REGS_PER_CH; i++) begin
                    ctrl_r[c][i] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 1; i < REGS_PER_CH - 1; i++) begin
                    if (wr_reg_s && (w_rch_s == CH_W'(c)) && (w_idx_s == RI_W'(i))) begin
                        ctrl_r[c][i] <= hold_data_r;
                    end else begin
                        ctrl_r[c][i] <= ctrl_r[c][i];
                    end
                end
            end
        end
    end

    // One-cycle command pulse carrying the written data bits.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cmd_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cmd_r[c] <= (wr_cmd_s && (w_rch_s == CH_W'(c))) ? hold_data_r : '0;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign Cmd_Pulse[c*DATA_W +: DATA_W] = cmd_r[c];
        for (genvar i = 0; i < REGS_PER_CH; i++) begin : g_reg
            assign Ctrl_Reg[(c*REGS_PER_CH+i)*DATA_W +: DATA_W] = ctrl_r[c][i];
        end
    end

    // ------------------------------------------------------------------
    // Waveform-RAM write port and error counter
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] ram_we_r;
    logic [RAM_AW-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_data_r;
    logic [7:0]        err_cnt_r;

    // RAM write strobe per channel; shared address/data hold between writes.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ram_we_r   <= '0;
            ram_addr_r <= '0;
            ram_data_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                ram_we_r[c] <= wr_ram_s && (w_mch_s == CH_W'(c));
            end
            if (wr_ram_s) begin
                ram_addr_r <= w_word_s;
                ram_data_r <= hold_data_r;
            end else begin
                ram_addr_r <= ram_addr_r;
                ram_data_r <= ram_data_r;
            end
        end
    end

    // Saturating count of writes that hit no mapped resource.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            err_cnt_r <= 8'd0;
        end else if (wr_err_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign Ram_We   = ram_we_r;
    assign Ram_Addr = ram_addr_r;
    assign Ram_Data = ram_data_r;
    assign Err_Cnt  = err_cnt_r;

    // ------------------------------------------------------------------
    // Readback. The CPU keeps the address stable for the whole NRD low
    // phase, so the pad address is decoded directly at the read event.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] status_s [NUM_CH];
    logic [RPG_W-1:0]  r_rpage_s;
    logic [CH_W-1:0]   r_ch_s;
    logic [RI_W-1:0]   r_idx_s;
    logic [DATA_W-1:0] rd_val_s;
    logic [DATA_W-1:0] data_out_r;
    logic              bus_oe_r;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
        assign status_s[c] = Status_In[c*DATA_W +: DATA_W];
    end

    assign r_rpage_s = CPU_Addr[ADDR_W-1:RPG_LSB];
    assign r_ch_s    = CPU_Addr[RI_W+CH_W:RI_W+1];
    assign r_idx_s   = CPU_Addr[RI_W:1];

    // Select the readback word; command slot, RAM and unmapped read as zero.
    always_comb begin
        rd_val_s = '0;
        if ((r_rpage_s == REG_PG) && ch_ok(r_ch_s)) begin
            if (r_idx_s == IDX_STAT) begin
                rd_val_s = status_s[r_ch_s];
            end else if (r_idx_s == IDX_CMD) begin
                rd_val_s = '0;
            end else begin
                rd_val_s = ctrl_r[r_ch_s][r_idx_s];
            end
        end else begin
            rd_val_s = '0;
        end
    end

    // Read data register (held until the next read) and pad output enable.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_out_r <= '0;
            bus_oe_r   <= 1'b0;
        end else begin
            if (rd_evt_s) begin
                data_out_r <= rd_val_s;
            end else begin
                data_out_r <= data_out_r;
            end
            bus_oe_r <= sync_ok_s & ~sncs_s & ~snrd_s & snwe_s;
        end
    end

    assign CPU_Data_Out = data_out_r;
    assign Bus_Oe       = bus_oe_r;

endmodule

// File: tb/tb_cpu_bus_regbank_ctrl.sv
// Randomised, scoreboard-checked bench for cpu_bus_regbank_ctrl.
module tb_cpu_bus_regbank_ctrl;

    localparam int ADDR_W   = 26;
    localparam int DATA_W   = 16;
    localparam int NUM_CH   = 2;
    localparam int REGS     = 8;
    localparam int RAM_AW   = 12;
    localparam int SYNC     = 2;
    localparam int CTRL_W   = NUM_CH * REGS * DATA_W;
    localparam int REG_SPAN = 2 * REGS * NUM_CH;          // bytes in register region
    localparam int RAM_SPAN = 2 * (1 << RAM_AW) * NUM_CH; // bytes in RAM region

    logic                     Clock = 1'b0;
    logic                     Reset;
    logic                     CPU_NCS, CPU_NWE, CPU_NRD;
    logic [ADDR_W-1:0]        CPU_Addr;
    logic [DATA_W-1:0]        CPU_Data_In;
    logic [DATA_W-1:0]        CPU_Data_Out;
    logic                     Bus_Oe;
    logic [NUM_CH*DATA_W-1:0] Status_In;
    logic [CTRL_W-1:0]        Ctrl_Reg;
    logic [NUM_CH*DATA_W-1:0] Cmd_Pulse;
    logic [NUM_CH-1:0]        Ram_We;
    logic [RAM_AW-1:0]        Ram_Addr;
    logic [DATA_W-1:0]        Ram_Data;
    logic [7:0]               Err_Cnt;

    always #5 Clock = ~Clock;

    cpu_bus_regbank_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .REGS_PER_CH(REGS),
        .RAM_AW(RAM_AW), .SYNC_STAGES(SYNC), .REG_PAGE(0), .RAM_PAGE(1)
    ) dut (
        .Clock(Clock), .Reset(Reset), .CPU_NCS(CPU_NCS), .CPU_NWE(CPU_NWE),
        .CPU_NRD(CPU_NRD), .CPU_Addr(CPU_Addr), .CPU_Data_In(CPU_Data_In),
        .CPU_Data_Out(CPU_Data_Out), .Bus_Oe(Bus_Oe), .Status_In(Status_In),
        .Ctrl_Reg(Ctrl_Reg), .Cmd_Pulse(Cmd_Pulse), .Ram_We(Ram_We),
        .Ram_Addr(Ram_Addr), .Ram_Data(Ram_Data), .Err_Cnt(Err_Cnt)
    );

    typedef struct {
        logic [NUM_CH-1:0] we;
        logic [RAM_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } ram_exp_t;

    ram_exp_t                 ram_q[$];
    logic [NUM_CH*DATA_W-1:0] cmd_q[$];
    logic [CTRL_W-1:0]        ctrl_q[$];
    logic [7:0]               err_q[$];
    logic [DATA_W-1:0]        rd_q[$];

    // Reference model state
    logic [DATA_W-1:0] m_reg [NUM_CH][REGS];
    int                m_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CTRL_W-1:0] model_flat();
        logic [CTRL_W-1:0] v = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < REGS; i++)
                v[(c*REGS+i)*DATA_W +: DATA_W] = m_reg[c][i];
        return v;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < REGS; i++)
                m_reg[c][i] = '0;
        m_err = 0;
    endfunction

    function automatic void model_err();
        if (m_err < 255) begin
            m_err++;
            err_q.push_back(8'(m_err));
        end
    endfunction

    // Predict the effect of one CPU write from the address map.
    function automatic void model_write(input int unsigned a, input logic [DATA_W-1:0] d);
        int unsigned w = a / 2;
        int unsigned ch, idx, word;
        logic [NUM_CH*DATA_W-1:0] cv;
        ram_exp_t re;
        if (a / REG_SPAN == 0) begin
            ch  = (w / REGS) % NUM_CH;
            idx = w % REGS;
            if (idx == 0) begin
                if (d != '0) begin
                    cv = '0;
                    cv[ch*DATA_W +: DATA_W] = d;
                    cmd_q.push_back(cv);
                end
            end else if (idx < REGS - 1) begin
                if (m_reg[ch][idx] != d) begin
                    m_reg[ch][idx] = d;
                    ctrl_q.push_back(model_flat());
                end
            end
        end else if (a / RAM_SPAN == 1) begin
            ch   = (w >> RAM_AW) % NUM_CH;
            word = w % (1 << RAM_AW);
            re.we   = NUM_CH'(1 << ch);
            re.addr = RAM_AW'(word);
            re.data = d;
            ram_q.push_back(re);
        end else begin
            model_err();
        end
    endfunction

    function automatic logic [DATA_W-1:0] model_read(input int unsigned a);
        int unsigned w = a / 2;
        int unsigned ch  = (w / REGS) % NUM_CH;
        int unsigned idx = w % REGS;
        if (a / REG_SPAN != 0) return '0;
        if (idx == REGS - 1) return Status_In[ch*DATA_W +: DATA_W];
        if (idx == 0) return '0;
        return m_reg[ch][idx];
    endfunction

    task automatic write_bus(input int unsigned a, input logic [DATA_W-1:0] d);
        model_write(a, d);
        @(posedge Clock); #3;
        CPU_Addr = ADDR_W'(a); CPU_Data_In = d; CPU_NCS = 1'b0;
        @(posedge Clock); #3; CPU_NWE = 1'b0;
        repeat (SYNC + 2) @(posedge Clock);
        #3; CPU_NWE = 1'b1;
        @(posedge Clock); #3; CPU_NCS = 1'b1;
        repeat (SYNC + 3) @(posedge Clock);
    endtask

    task automatic read_bus(input int unsigned a);
        logic [DATA_W-1:0] ev;
        ev = model_read(a);
        rd_q.push_back(ev);
        @(posedge Clock); #3;
        CPU_Addr = ADDR_W'(a); CPU_NCS = 1'b0;
        @(posedge Clock); #3; CPU_NRD = 1'b0;
        repeat (SYNC + 2) @(posedge Clock);
        #1;
        check("rd_latency_data", CPU_Data_Out, ev);
        check("rd_bus_oe", Bus_Oe, 1'b1);
        @(posedge Clock); #3; CPU_NRD = 1'b1;
        @(posedge Clock); #3; CPU_NCS = 1'b1;
        repeat (SYNC + 3) @(posedge Clock);
    endtask

    task automatic do_reset();
        @(posedge Clock); #3; Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #3; Reset = 1'b0;
        model_clear();
    endtask

    // Monitor: compare every DUT output event against the head of its queue.
    logic [CTRL_W-1:0] prev_ctrl;
    logic [7:0]        prev_err;
    logic              prev_oe;

    always @(negedge Clock) begin
        if (Reset) begin
            prev_ctrl <= Ctrl_Reg;
            prev_err  <= Err_Cnt;
            prev_oe   <= 1'b0;
        end else begin
            if (Ram_We != '0) begin
                if (ram_q.size() == 0) check("ram_we_unexpected", Ram_We, '0);
                else begin
                    check("ram_we", Ram_We, ram_q[0].we);
                    check("ram_addr", Ram_Addr, ram_q[0].addr);
                    check("ram_data", Ram_Data, ram_q[0].data);
                    void'(ram_q.pop_front());
                end
            end
            if (Cmd_Pulse != '0) begin
                if (cmd_q.size() == 0) check("cmd_unexpected", Cmd_Pulse, '0);
                else begin
                    check("cmd_pulse", Cmd_Pulse, cmd_q[0]);
                    void'(cmd_q.pop_front());
                end
            end
            if (Ctrl_Reg != prev_ctrl) begin
                if (ctrl_q.size() == 0) check("ctrl_unexpected", Ctrl_Reg, prev_ctrl);
                else begin
                    check("ctrl_reg", Ctrl_Reg, ctrl_q[0]);
                    void'(ctrl_q.pop_front());
                end
            end
            if (Err_Cnt != prev_err) begin
                if (err_q.size() == 0) check("err_unexpected", Err_Cnt, prev_err);
                else begin
                    check("err_cnt", Err_Cnt, err_q[0]);
                    void'(err_q.pop_front());
                end
            end
            if (prev_oe && !Bus_Oe) begin
                if (rd_q.size() == 0) check("bus_oe_unexpected", prev_oe, 1'b0);
                else begin
                    check("rd_data", CPU_Data_Out, rd_q[0]);
                    void'(rd_q.pop_front());
                end
            end
            prev_ctrl <= Ctrl_Reg;
            prev_err  <= Err_Cnt;
            prev_oe   <= Bus_Oe;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a, kind, ch;
        int          err_before;
        Reset = 1'b1; CPU_NCS = 1'b1; CPU_NWE = 1'b1; CPU_NRD = 1'b1;
        CPU_Addr = '0; CPU_Data_In = '0; Status_In = '0;
        model_clear();
        do_reset();
        @(posedge Clock); #1;
        check("rst_ctrl", Ctrl_Reg, '0);
        check("rst_cmd", Cmd_Pulse, '0);
        check("rst_ram_we", Ram_We, '0);
        check("rst_ram_addr", Ram_Addr, '0);
        check("rst_ram_data", Ram_Data, '0);
        check("rst_dout", CPU_Data_Out, '0);
        check("rst_oe", Bus_Oe, 1'b0);
        check("rst_err", Err_Cnt, 8'd0);

        // Register store, command pulse, RAM writes
        write_bus(32'h0004, 16'h1234);
        check("ctrl0_2", Ctrl_Reg[2*DATA_W +: DATA_W], 16'h1234);
        check("ctrl_after_w1", Ctrl_Reg, model_flat());
        write_bus(32'h0010, 16'h0005);
        read_bus(32'h0010);
        write_bus(32'h4000 + 2*32'h07F, 16'hABCD);
        write_bus(32'h6000, 16'hABCD);

        // Status readback and read-only status write
        Status_In[1*DATA_W +: DATA_W] = 16'h00C3;
        read_bus(32'h001E);
        err_before = m_err;
        write_bus(32'h001E, 16'h7777);
        check("err_status_write", Err_Cnt, 8'(err_before));

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 4);
            ch   = $urandom_range(0, NUM_CH - 1);
            case (kind)
                0, 1: a = ch * REGS * 2 + $urandom_range(0, REGS - 1) * 2;
                2:    a = 32'h4000 + ch * 32'h2000 + $urandom_range(0, 4095) * 2;
                3:    a = $urandom_range(32'h4000, 32'h1FF_FFFF) * 2;
                default: a = ch * REGS * 2 + $urandom_range(0, REGS - 1) * 2;
            endcase
            if (kind == 4 || ($urandom_range(0, 3) == 0)) begin
                Status_In = {16'($urandom), 16'($urandom)};
                read_bus(a);
            end else begin
                write_bus(a, 16'($urandom));
            end
        end
        check("ctrl_after_random", Ctrl_Reg, model_flat());

        // Error counter saturation
        for (int n = 0; n < 300; n++) write_bus(32'h100000, 16'($urandom));
        check("err_saturated", Err_Cnt, 8'd255);
        check("ctrl_after_unmapped", Ctrl_Reg, model_flat());

        // Reset while a write is in flight, NWE still low at release
        @(posedge Clock); #3;
        CPU_Addr = 26'h0004; CPU_Data_In = 16'h5A5A; CPU_NCS = 1'b0;
        @(posedge Clock); #3; CPU_NWE = 1'b0;
        repeat (SYNC + 2) @(posedge Clock);
        #3; Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #3; Reset = 1'b0;
        model_clear();
        repeat (SYNC + 2) @(posedge Clock);
        #3; CPU_NWE = 1'b1;
        @(posedge Clock); #3; CPU_NCS = 1'b1;
        repeat (SYNC + 3) @(posedge Clock);
        #1;
        check("ctrl_after_midwrite_reset", Ctrl_Reg, '0);
        check("err_after_midwrite_reset", Err_Cnt, 8'd0);

        // NCS released before NWE: no write
        @(posedge Clock); #3;
        CPU_Addr = 26'h0004; CPU_Data_In = 16'hA55A; CPU_NCS = 1'b0;
        @(posedge Clock); #3; CPU_NWE = 1'b0;
        repeat (SYNC + 2) @(posedge Clock);
        #3; CPU_NCS = 1'b1;
        @(posedge Clock); #3; CPU_NWE = 1'b1;
        repeat (SYNC + 3) @(posedge Clock);
        #1;
        check("ctrl_after_ncs_first", Ctrl_Reg, model_flat());

        // A normal write after all that still works
        write_bus(32'h0006, 16'h0F0F);
        repeat (20) @(posedge Clock);
        #1;
        check("ctrl_final", Ctrl_Reg, model_flat());
        check("ram_q_left", ram_q.size(), 0);
        check("cmd_q_left", cmd_q.size(), 0);
        check("ctrl_q_left", ctrl_q.size(), 0);
        check("err_q_left", err_q.size(), 0);
        check("rd_q_left", rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
